// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM encodings and line-level constants for the parity serial link.
package parity_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_BIT   = 1'b0;
  localparam logic STOP_BIT    = 1'b1;
  localparam logic PARITY_EVEN = 1'b0;
endpackage

// File: rtl/baud_tick_counter.sv
// baud_tick_counter: divides clk into bit periods, tick high on the last cycle of each period.
module baud_tick_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] r_cnt;
  assign tick = r_cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (clear || tick) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: even-parity UART-style serializer (start, data LSB first, parity, stop).
module parity_serial_tx
  import parity_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy,
  output logic              tx_done
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [BW-1:0]     r_bit;
  logic              r_par;
  logic              r_tx;
  logic              w_tick;
  logic              w_clear;
  assign w_shift_nxt = r_shift >> 1;
  assign w_clear     = r_state == IDLE;
  assign ready_out   = r_state == IDLE;
  assign busy        = !ready_out;
  assign tx_out      = r_tx;
  assign tx_done     = r_state == STOP && w_tick;
  baud_tick_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(w_clear),
    .tick (w_tick)
  );
  // tx_out is loaded with the next bit on the same edge the state advances, so line and state stay aligned
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_par   <= 1'b0;
      r_tx    <= LINE_IDLE;
    end else begin
      case (r_state)
        IDLE: if (valid_in) begin
          r_shift <= data_in;
          r_par   <= (^data_in) ^ PARITY_EVEN;
          r_tx    <= START_BIT;
          r_state <= START;
        end
        START: if (w_tick) begin
          r_bit   <= '0;
          r_tx    <= r_shift[0];
          r_state <= DATA;
        end
        DATA: if (w_tick) begin
          r_shift <= w_shift_nxt;
          if (r_bit == LAST_BIT) begin
            r_tx    <= r_par;
            r_state <= PARITY;
          end else begin
            r_bit <= r_bit + 1'b1;
            r_tx  <= w_shift_nxt[0];
          end
        end
        PARITY: if (w_tick) begin
          r_tx    <= STOP_BIT;
          r_state <= STOP;
        end
        STOP: if (w_tick) begin
          r_tx    <= LINE_IDLE;
          r_state <= IDLE;
        end
        default: begin
          r_tx    <= LINE_IDLE;
          r_state <= IDLE;
        end
      endcase
    end
endmodule

// File: doc/parity_serial_tx.md
Name: parity_serial_tx

Overview:
Downstream serializer for the even-parity path. It accepts a parallel data word with a valid/ready handshake and computes the even parity bit internally. It then shifts out a UART-style frame on a single line, LSB first: start, data, parity, stop. It feeds the serial link whose receiver runs the even-parity check.

Parameters:
DATA_W, 4, number of data bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles each frame bit is held on tx_out (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  DATA_W  parallel word to transmit
valid_in  input  1  data_in is valid; transfer occurs when valid_in && ready_out at a clk edge
ready_out  output  1  block can accept a word (high only in IDLE)
tx_out  output  1  serial line; idle/stop level 1, start level 0
busy  output  1  frame in progress (state != IDLE)
tx_done  output  1  one-cycle pulse on the final cycle of the stop bit

Behaviour:
- Reset (rst_n low, takes effect immediately, asynchronous): state=IDLE, tx_out=1, ready_out=1, busy=0, tx_done=0, bit and tick counters=0, shift register=0.
- Reset mid-frame aborts the frame. tx_out returns to 1 at once, and no tx_done is produced.
- One clock, clk; reset is asynchronous and active-low (rst_n).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out=1, ready_out=1.
  - On valid_in=1, latch data_in into the shift register.
  - Latch parity = XOR-reduction of data_in (even parity: total ones in data+parity is even).
  - Go to START.
- START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx_out = shift_reg[0]. Each bit is held CLKS_PER_BIT cycles, then the register shifts right.
  - After DATA_W bits, go to PARITY.
- PARITY: tx_out = latched parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx_out=1 for CLKS_PER_BIT cycles.
  - tx_done=1 on the last of those cycles.
  - Then go to IDLE.
- tx_out is registered. The start bit appears on the first clk edge after the accepting edge.
- Frame length from first start cycle to last stop cycle: (DATA_W+3)*CLKS_PER_BIT cycles.
- Back-to-back transfers: exactly one IDLE cycle (tx_out=1, ready_out=1) separates consecutive frames, even when valid_in is held high.
- data_in and valid_in are ignored while busy. The latched word cannot be corrupted mid-frame.
- Tick counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Width: $clog2(CLKS_PER_BIT) with a minimum of 1 bit.
  - CLKS_PER_BIT=1 yields one cycle per bit with no stall.
- Bit counter: counts 0..DATA_W-1 during DATA only; cleared on entry to DATA.
- busy = !ready_out at all times.

Decomposition:
- Shared package/include parity_pkg:
  - FSM state encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits.
  - Line-level constants: LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
  - Parity mode constant PARITY_EVEN, for reuse by the matching receiver.
- One sub-module, baud_tick_counter:
  - Parameter CLKS_PER_BIT.
  - Ports: clk, rst_n, clear, tick (high on the last cycle of each bit period).
- Parity is a single reduction XOR inline; no sub-module.

Test Plan (DATA_W=4, CLKS_PER_BIT=4):
1. Reset: rst_n=0 then hold. Required: tx_out=1, ready_out=1, busy=0, tx_done=0 before any clk edge and after release.
2. data_in=4'b1010, valid_in pulsed 1 cycle. Required: tx_out sequence 0 | 0,1,0,1 | 0 | 1, each held 4 cycles (28 cycles total). tx_done pulses only on cycle 28. ready_out=0 for all 28 cycles.
3. data_in=4'b0111. Required: data bits 1,1,1,0, parity bit=1. A reference receiver model sees the frame as even (4 ones).
4. valid_in held 1 with 4'b0000 then 4'b0010. Required: parity 0 then 1, and exactly one tx_out=1/ready_out=1 cycle between the first stop end and the second start.
5. rst_n asserted during the 2nd data bit of 4'b1111. Required: tx_out=1 immediately, no tx_done. After release, the next word 4'b0001 produces a clean frame with parity 1.
6. During a 4'b1100 frame, toggle data_in to 4'b0011 and pulse valid_in. Required: transmitted bits stay 0,0,1,1 with parity 0, and no second frame starts from the ignored valid.
